// File: rtl/sop_rr_arbiter.sv
// sop_rr_arbiter
//   Shares one registered sum-of-products unit among N_REQ requesters with
//   round-robin arbitration. For the granted requester's 10-bit operand slice
//   (bits [0..5] = a..f, [6..9] = g..j) the unit produces
//      y[0] = (a&b&c) | (d&e&f)
//      y[1] = (g&h)   | (i&j)
//   and loads it, with the requester index, into a single result register
//   drained through a valid/ready handshake (one evaluation per cycle).
//
// Ports
//   clk        : system clock, all state on the rising edge
//   reset      : synchronous active-high reset
//   req        : one request bit per requester, held until granted
//   req_data   : operand slices, slice k = req_data[10k+9:10k]
//   gnt        : one-hot combinational grant
//   resp_valid : result register holds a valid result
//   resp_ready : consumer accepts the result this cycle
//   resp_id    : requester index of the held result
//   resp_y     : {y[1], y[0]} of the held result
//   clr_stats  : clears the per-requester grant counters
//   gnt_cnt    : per-requester grant counters, slice k for requester k
//
// Build option
//   SOP_RR_ARBITER_STATS_EN : when defined, builds saturating grant counters.
//   When undefined, gnt_cnt reads 0 and clr_stats is ignored.

module sop_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*10-1:0]    req_data,
   output logic [N_REQ-1:0]       gnt,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [ID_W-1:0]        resp_id,
   output logic [1:0]             resp_y,
   input  logic                   clr_stats,
   output logic [N_REQ*CNT_W-1:0] gnt_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t          r_state;
   logic [ID_W-1:0] r_rr_ptr;
   logic [ID_W-1:0] r_resp_id;
   logic [1:0]      r_resp_y;

   logic                 w_slot_free;
   logic [2*N_REQ-1:0]   w_req_dbl;
   logic [2*N_REQ-1:0]   w_req_rot;
   logic                 w_found;
   logic [ID_W-1:0]      w_gnt_id;
   logic                 w_any_gnt;
   logic [9:0]           w_slice [N_REQ];
   logic [9:0]           w_sel;
   logic [1:0]           w_y;

   assign resp_valid  = (r_state == FULL);
   assign resp_id     = r_resp_id;
   assign resp_y      = r_resp_y;
   assign w_slot_free = !resp_valid || resp_ready;

   // Rotating a doubled copy of req puts requester (rr_ptr+1) mod N_REQ at
   // bit 0, so the lowest set bit of the rotated vector is the winner.
   assign w_req_dbl = {req, req};
   assign w_req_rot = w_req_dbl >> (int'(r_rr_ptr) + 1);

   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      // Descending scan: the last hit written is the lowest rotated index.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_req_rot[i]) begin
            w_found  = 1'b1;
            w_gnt_id = ID_W'((int'(r_rr_ptr) + 1 + i) % N_REQ);
         end
      end
   end

   assign w_any_gnt = w_found && w_slot_free && !reset;
   assign gnt       = w_any_gnt ? (N_REQ'(1) << w_gnt_id) : '0;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign w_slice[gi] = req_data[gi*10 +: 10];
      end
   endgenerate

   // Shared combinational SOP unit fed by the granted slice.
   assign w_sel  = w_slice[w_gnt_id];
   assign w_y[0] = (w_sel[0] & w_sel[1] & w_sel[2]) | (w_sel[3] & w_sel[4] & w_sel[5]);
   assign w_y[1] = (w_sel[6] & w_sel[7]) | (w_sel[8] & w_sel[9]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= EMPTY;
         r_rr_ptr  <= ID_W'(N_REQ - 1);
         r_resp_id <= '0;
         r_resp_y  <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_any_gnt) begin
                  r_state   <= FULL;
                  r_rr_ptr  <= w_gnt_id;
                  r_resp_id <= w_gnt_id;
                  r_resp_y  <= w_y;
               end
            end
            FULL: begin
               // A grant here implies resp_ready, so the reload is a
               // back-to-back transfer and valid stays high.
               if (w_any_gnt) begin
                  r_rr_ptr  <= w_gnt_id;
                  r_resp_id <= w_gnt_id;
                  r_resp_y  <= w_y;
               end else if (resp_ready) begin
                  r_state <= EMPTY;
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

`ifdef SOP_RR_ARBITER_STATS_EN
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
         logic [CNT_W-1:0] r_cnt;
         always_ff @(posedge clk) begin
            if (reset || clr_stats) begin
               r_cnt <= '0;
            end else if (gnt[gi] && (r_cnt != {CNT_W{1'b1}})) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
         assign gnt_cnt[gi*CNT_W +: CNT_W] = r_cnt;
      end
   endgenerate
`else
   logic w_unused_clr_stats;
   assign w_unused_clr_stats = clr_stats;
   assign gnt_cnt            = '0;
`endif

endmodule

// File: tb/tb_sop_rr_arbiter.sv
module tb_sop_rr_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;
`ifdef SOP_RR_ARBITER_STATS_EN
   localparam int CW  = 4;
`else
   localparam int CW  = 16;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*10-1:0] req_data;
   logic [N-1:0]    gnt;
   logic            resp_valid;
   logic            resp_ready;
   logic [IDW-1:0]  resp_id;
   logic [1:0]      resp_y;
   logic            clr_stats;
   logic [N*CW-1:0] gnt_cnt;

   sop_rr_arbiter #(.N_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_y     (resp_y),
      .clr_stats  (clr_stats),
      .gnt_cnt    (gnt_cnt)
   );

   always #5 clk = ~clk;

   int n_checks   = 0;
   int n_failures = 0;

   // Reference model state
   logic         m_valid;
   int           m_ptr;
   int           m_cnt [N];
   logic [3:0]   sb_q [$];   // {id, y} expected results in issue order
   logic [N-1:0] last_gnt;
   int           grant_count;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] sop(input logic [9:0] v);
      logic a, b, c, d, e, f, g, h, i, j;
      {j, i, h, g, f, e, d, c, b, a} = v;
      return {(g & h) | (i & j), (a & b & c) | (d & e & f)};
   endfunction

   // One clock: checks outputs at the falling edge against the model, then
   // advances the model across the following rising edge.
   task automatic cycle();
      logic [N-1:0]    exp_gnt;
      int              exp_id;
      logic [N*CW-1:0] exp_cnt;
      logic [3:0]      front;
      @(negedge clk);
      exp_gnt = '0;
      exp_id  = -1;
      if (!reset && (!m_valid || resp_ready)) begin
         for (int o = 1; o <= N; o++) begin
            if (exp_id < 0 && req[(m_ptr + o) % N]) exp_id = (m_ptr + o) % N;
         end
         if (exp_id >= 0) exp_gnt[exp_id] = 1'b1;
      end
      check("gnt", 64'(gnt), 64'(exp_gnt));
      check("resp_valid", 64'(resp_valid), 64'(m_valid));
      if (m_valid) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 64'(1), 64'(0));
         end else begin
            front = sb_q[0];
            check("resp_id", 64'(resp_id), 64'(front[3:2]));
            check("resp_y", 64'(resp_y), 64'(front[1:0]));
            if (resp_ready && !reset) void'(sb_q.pop_front());
         end
      end
      for (int k = 0; k < N; k++) exp_cnt[k*CW +: CW] = CW'(m_cnt[k]);
      check("gnt_cnt", 64'(gnt_cnt), 64'(exp_cnt));
      last_gnt = gnt;
      if (gnt != '0) grant_count++;
      // model update for the coming edge
      if (reset) begin
         m_valid = 1'b0;
         m_ptr   = N - 1;
         sb_q.delete();
         for (int k = 0; k < N; k++) m_cnt[k] = 0;
      end else begin
         if (exp_id >= 0) begin
            sb_q.push_back({2'(exp_id), sop(req_data[exp_id*10 +: 10])});
            m_valid = 1'b1;
            m_ptr   = exp_id;
         end else if (resp_ready) begin
            m_valid = 1'b0;
         end
`ifdef SOP_RR_ARBITER_STATS_EN
         for (int k = 0; k < N; k++) begin
            if (clr_stats) m_cnt[k] = 0;
            else if (exp_gnt[k] && m_cnt[k] < (2**CW - 1)) m_cnt[k]++;
         end
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      req        = '0;
      req_data   = '0;
      resp_ready = 1'b1;
      clr_stats  = 1'b0;
      grant_count = 0;
      repeat (2) @(posedge clk);
      #1;
      m_valid = 1'b0;
      m_ptr   = N - 1;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;

      // Reset state
      cycle();
      check("rst_valid", 64'(resp_valid), 64'(0));
      check("rst_id", 64'(resp_id), 64'(0));
      check("rst_y", 64'(resp_y), 64'(0));
      reset = 1'b0;

      // Single request, function check
      req      = 4'b0100;
      req_data = {10'h000, 10'b11_00_111000, 10'h3FF, 10'h000};
      cycle();
      check("single_gnt", 64'(last_gnt), 64'(4'b0100));
      req = '0;
      cycle();
      check("single_id", 64'(resp_id), 64'(2));
      check("single_y", 64'(resp_y), 64'(sop(10'b11_00_111000)));
      cycle();

      // Reset mid-result: grant issued, result pending, then reset
      resp_ready = 1'b0;
      req        = 4'b0010;
      cycle();
      req   = 4'b1111;
      reset = 1'b1;
      cycle();
      check("rst_mid_gnt", 64'(last_gnt), 64'(0));
      reset      = 1'b0;
      resp_ready = 1'b1;
      check("rst_mid_valid", 64'(resp_valid), 64'(0));
      cycle();
      check("rst_first_gnt", 64'(last_gnt), 64'(4'b0001));

      // Full round-robin from the reset pointer
      do_reset();
      req      = 4'b1111;
      req_data = {10'h3C0, 10'h038, 10'h007, 10'h2A5};
      begin
         logic [N-1:0] seq [5];
         seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
         for (int s = 0; s < 5; s++) begin
            cycle();
            check("rr_seq", 64'(last_gnt), 64'(seq[s]));
         end
      end
      req = '0;
      cycle();
      cycle();

      // Backpressure
      do_reset();
      req         = 4'b0011;
      resp_ready  = 1'b0;
      grant_count = 0;
      for (int s = 0; s < 5; s++) begin
         cycle();
         if (last_gnt[0]) req[0] = 1'b0;
      end
      check("bp_grants", 64'(grant_count), 64'(1));
      resp_ready = 1'b1;
      cycle();
      check("bp_release_gnt", 64'(last_gnt), 64'(4'b0010));
      req = '0;
      cycle();
      cycle();

      // Exhaustive operand sweep through requester 3
      req = 4'b1000;
      for (int v = 0; v < 1024; v++) begin
         req_data[39:30] = 10'(v);
         cycle();
      end
      req = '0;
      cycle();
      cycle();

      // Grant counters: saturation then clear coinciding with a grant
      do_reset();
      req      = 4'b0010;
      req_data = 40'h12345_6789A;
      for (int s = 0; s < 20; s++) cycle();
`ifdef SOP_RR_ARBITER_STATS_EN
      check("cnt_sat", 64'(gnt_cnt[1*CW +: CW]), 64'(15));
`else
      check("cnt_off", 64'(gnt_cnt[1*CW +: CW]), 64'(0));
`endif
      clr_stats = 1'b1;
      cycle();
      clr_stats = 1'b0;
      req       = '0;
      cycle();
      check("cnt_clr", 64'(gnt_cnt[1*CW +: CW]), 64'(0));
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule
